// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: valid/ready word load, 1 bit/clock out.
// Optional even-parity trailer bit when PARITY_EN is defined.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             tx_done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PARITY_EN
  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    SHIFT
  } state_t;
`endif

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_ser_out;
  logic             r_ser_valid;
  logic             r_busy;
  logic             r_tx_done;
`ifdef PARITY_EN
  logic             r_par;
`endif

  logic             w_last;
  logic             w_ready_st;
  logic             w_xfer;
  logic             w_first;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_load_shift;
  logic [WIDTH-1:0] w_next_shift;
  logic [CW-1:0]    w_cnt_inc;

  assign w_last = (r_state == SHIFT) && (r_cnt == LAST);

`ifdef PARITY_EN
  assign w_ready_st = (r_state == IDLE) || (r_state == PARITY);
`else
  assign w_ready_st = (r_state == IDLE) || w_last;
`endif

  assign load_ready = !rst && w_ready_st;
  assign w_xfer     = load_valid && load_ready;

  // The first bit leaves straight from load_data; the register
  // holds the remaining bits already advanced by one position.
  assign w_first      = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
  assign w_load_shift = MSB_FIRST ? (load_data << 1) : (load_data >> 1);
  assign w_next_bit   = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
  assign w_next_shift = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
  assign w_cnt_inc    = r_cnt + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_ser_out   <= 1'b0;
      r_ser_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_tx_done   <= 1'b0;
`ifdef PARITY_EN
      r_par       <= 1'b0;
`endif
    end else if (w_xfer) begin
      r_state     <= SHIFT;
      r_cnt       <= '0;
      r_shift     <= w_load_shift;
      r_ser_out   <= w_first;
      r_ser_valid <= 1'b1;
      r_busy      <= 1'b1;
      r_tx_done   <= 1'b0;
`ifdef PARITY_EN
      r_par       <= ^load_data;
`endif
    end else begin
      unique case (r_state)
        SHIFT: begin
          if (w_last) begin
`ifdef PARITY_EN
            r_state   <= PARITY;
            r_ser_out <= r_par;
            r_tx_done <= 1'b1;
`else
            r_state     <= IDLE;
            r_ser_out   <= 1'b0;
            r_ser_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_tx_done   <= 1'b0;
`endif
          end else begin
            r_cnt     <= w_cnt_inc;
            r_shift   <= w_next_shift;
            r_ser_out <= w_next_bit;
`ifdef PARITY_EN
            r_tx_done <= 1'b0;
`else
            r_tx_done <= (w_cnt_inc == LAST);
`endif
          end
        end
`ifdef PARITY_EN
        PARITY: begin
          r_state     <= IDLE;
          r_ser_out   <= 1'b0;
          r_ser_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_tx_done   <= 1'b0;
        end
`endif
        default: begin
          r_state     <= IDLE;
          r_ser_out   <= 1'b0;
          r_ser_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_tx_done   <= 1'b0;
        end
      endcase
    end
  end

  assign ser_out   = r_ser_out;
  assign ser_valid = r_ser_valid;
  assign busy      = r_busy;
  assign tx_done   = r_tx_done;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: LSB-first and MSB-first instances
// share stimulus; per-cycle vector table plus a streaming sequence.
module tb_piso_serializer;

  localparam int W = 4;
`ifdef PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic         clk;
  logic         rst;
  logic [W-1:0] load_data;
  logic         load_valid;
  logic         rdy_l, so_l, sv_l, bsy_l, dn_l;
  logic         rdy_m, so_m, sv_m, bsy_m, dn_m;

  int total;
  int bad;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .load_data(load_data),
    .load_valid(load_valid), .load_ready(rdy_l),
    .ser_out(so_l), .ser_valid(sv_l), .busy(bsy_l), .tx_done(dn_l)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .load_data(load_data),
    .load_valid(load_valid), .load_ready(rdy_m),
    .ser_out(so_m), .ser_valid(sv_m), .busy(bsy_m), .tx_done(dn_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         lv;
    logic [W-1:0] d;
    logic         rdy;
    logic         vld;
    logic         so;
    logic         som;
    logic         bsy;
    logic         dn;
  } vec_t;

  vec_t tv[$];

  function automatic void add(input logic r, input logic lv,
                              input logic [W-1:0] d,
                              input logic rdy, input logic vld,
                              input logic so, input logic som,
                              input logic bsy, input logic dn);
    vec_t v;
    v.rst = r; v.lv = lv; v.d = d;
    v.rdy = rdy; v.vld = vld; v.so = so;
    v.som = som; v.bsy = bsy; v.dn = dn;
    tv.push_back(v);
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  logic [W-1:0] words [3];
  logic         bits  [$];
  int           k, ndone, gaps, started;
  logic [W-1:0] rebuilt;

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    load_valid = 1'b0;
    load_data = '0;
    @(posedge clk);

    // rst lv data | rdy vld so som bsy dn
    add(1, 1, 4'hB, 0, 0, 0, 0, 0, 0);
    add(1, 1, 4'hB, 0, 0, 0, 0, 0, 0);
    add(1, 1, 4'hB, 0, 0, 0, 0, 0, 0);
`ifdef PARITY_EN
    add(0, 1, 4'h7, 1, 0, 0, 0, 0, 0);
    add(0, 0, 4'h0, 0, 1, 1, 0, 1, 0);
    add(0, 0, 4'h0, 0, 1, 1, 1, 1, 0);
    add(0, 0, 4'h0, 0, 1, 1, 1, 1, 0);
    add(0, 0, 4'h0, 0, 1, 0, 1, 1, 0);
    add(0, 1, 4'h1, 1, 1, 1, 1, 1, 1);
    add(0, 0, 4'h0, 0, 1, 1, 0, 1, 0);
    add(0, 0, 4'h0, 0, 1, 0, 0, 1, 0);
    add(0, 0, 4'h0, 0, 1, 0, 0, 1, 0);
    add(0, 0, 4'h0, 0, 1, 0, 1, 1, 0);
    add(0, 0, 4'h0, 1, 1, 1, 1, 1, 1);
    add(0, 0, 4'h0, 1, 0, 0, 0, 0, 0);
`else
    add(0, 1, 4'hB, 1, 0, 0, 0, 0, 0);
    add(0, 0, 4'h0, 0, 1, 1, 1, 1, 0);
    add(0, 0, 4'h0, 0, 1, 1, 0, 1, 0);
    add(0, 0, 4'h0, 0, 1, 0, 1, 1, 0);
    add(0, 0, 4'h0, 1, 1, 1, 1, 1, 1);
    add(0, 0, 4'h0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 4'hA, 1, 0, 0, 0, 0, 0);
    add(0, 1, 4'hA, 0, 1, 0, 1, 1, 0);
    add(0, 1, 4'hA, 0, 1, 1, 0, 1, 0);
    add(0, 1, 4'hA, 0, 1, 0, 1, 1, 0);
    add(0, 1, 4'h5, 1, 1, 1, 0, 1, 1);
    add(0, 0, 4'h0, 0, 1, 1, 0, 1, 0);
    add(0, 0, 4'h0, 0, 1, 0, 1, 1, 0);
    add(0, 0, 4'h0, 0, 1, 1, 0, 1, 0);
    add(0, 0, 4'h0, 1, 1, 0, 1, 1, 1);
    add(0, 0, 4'h0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 4'hC, 1, 0, 0, 0, 0, 0);
    add(0, 0, 4'h0, 0, 1, 0, 1, 1, 0);
    add(0, 1, 4'h3, 0, 1, 0, 1, 1, 0);
    add(0, 1, 4'h3, 0, 1, 1, 0, 1, 0);
    add(0, 1, 4'h3, 1, 1, 1, 0, 1, 1);
    add(0, 0, 4'h0, 0, 1, 1, 0, 1, 0);
    add(0, 0, 4'h0, 0, 1, 1, 0, 1, 0);
    add(0, 0, 4'h0, 0, 1, 0, 1, 1, 0);
    add(0, 0, 4'h0, 1, 1, 0, 1, 1, 1);
    add(0, 0, 4'h0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 4'hF, 1, 0, 0, 0, 0, 0);
    add(0, 0, 4'h0, 0, 1, 1, 1, 1, 0);
    add(1, 0, 4'h0, 0, 1, 1, 1, 1, 0);
    add(0, 0, 4'h0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 4'h1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 4'h0, 0, 1, 1, 0, 1, 0);
    add(0, 0, 4'h0, 0, 1, 0, 0, 1, 0);
    add(0, 0, 4'h0, 0, 1, 0, 0, 1, 0);
    add(0, 0, 4'h0, 1, 1, 0, 1, 1, 1);
    add(0, 0, 4'h0, 1, 0, 0, 0, 0, 0);
`endif

    foreach (tv[i]) begin
      @(negedge clk);
      rst = tv[i].rst;
      load_valid = tv[i].lv;
      load_data = tv[i].d;
      #1;
      chk($sformatf("row%0d load_ready", i), rdy_l, tv[i].rdy);
      chk($sformatf("row%0d ser_valid", i), sv_l, tv[i].vld);
      chk($sformatf("row%0d ser_out", i), so_l, tv[i].so);
      chk($sformatf("row%0d ser_out_msb", i), so_m, tv[i].som);
      chk($sformatf("row%0d busy", i), bsy_l, tv[i].bsy);
      chk($sformatf("row%0d tx_done", i), dn_l, tv[i].dn);
      chk($sformatf("row%0d ready_msb", i), rdy_m, tv[i].rdy);
      chk($sformatf("row%0d done_msb", i), dn_m, tv[i].dn);
    end

    // Streaming: three words with load_valid held, expect a gapless stream
    words[0] = 4'h9;
    words[1] = 4'h6;
    words[2] = 4'hE;
    k = 0;
    ndone = 0;
    gaps = 0;
    started = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      rst = 1'b0;
      load_valid = (k < 3);
      load_data = (k < 3) ? words[k] : '0;
      #1;
      if (sv_l) begin
        bits.push_back(so_l);
        started = 1;
      end else if (started != 0 && bits.size() < 3 * FRAME) begin
        gaps++;
      end
      if (dn_l) ndone++;
      if (load_valid && rdy_l) k++;
      if (k == 3 && bits.size() >= 3 * FRAME && !bsy_l) break;
    end
    chk_int("stream words accepted", k, 3);
    chk_int("stream bit count", bits.size(), 3 * FRAME);
    chk_int("stream gaps", gaps, 0);
    chk_int("stream tx_done count", ndone, 3);
    if (bits.size() == 3 * FRAME) begin
      for (int w = 0; w < 3; w++) begin
        for (int b = 0; b < W; b++) rebuilt[b] = bits[w * FRAME + b];
        chk_int($sformatf("stream word%0d", w), int'(rebuilt), int'(words[w]));
`ifdef PARITY_EN
        chk($sformatf("stream parity%0d", w), bits[w * FRAME + W], ^words[w]);
`endif
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in serial-out transmitter. It is the sending end of the serial bit stream consumed by the team's shift-register receivers: it accepts a WIDTH-bit word over a valid/ready handshake and drives it onto a 1-bit serial line, one bit per clock, with a qualifying valid strobe. It sits between a word-level producer and any serial-input shift chain.

Parameters:
WIDTH, 4, data word width in bits; legal range >= 2.
MSB_FIRST, 0, bit order: 0 = bit 0 transmitted first (LSB-first); 1 = bit WIDTH-1 transmitted first.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous active-high reset.
load_data  input  WIDTH  word to transmit; sampled when load_valid && load_ready.
load_valid  input  1  producer has a word on load_data.
load_ready  output  1  block can accept a word this cycle.
ser_out  output  1  serial data bit.
ser_valid  output  1  ser_out carries a valid bit this cycle.
busy  output  1  a word is in flight: state is SHIFT, or PARITY when PARITY_EN is defined.
tx_done  output  1  one-cycle pulse during the final bit of a word.

Behaviour:
- Single clock, clk. Reset is synchronous and active-high on rst. Every register clears on the rising edge of clk while rst = 1.
- Reset values: ser_out = 0, ser_valid = 0, busy = 0, tx_done = 0, state = IDLE, bit counter = 0, shift register = 0.
- While rst = 1, load_ready is forced to 0.
- Handshake: a transfer occurs on a rising edge where load_valid = 1 and load_ready = 1. load_valid is ignored when load_ready = 0. Producer holds load_data stable while load_valid is high.
- load_ready is combinational from state and counter. It is 1 in IDLE, and also 1 during the final transmitted bit of a word (the last data bit, or the parity bit when PARITY_EN is defined). This allows back-to-back words with no idle gap.
- FSM states:
  - IDLE: ser_valid = 0, ser_out = 0. On transfer, load the shift register, clear the counter, go to SHIFT.
  - SHIFT: ser_valid = 1, and ser_out is the current bit selected by MSB_FIRST. The shift register shifts one position per cycle and the counter increments.
  - Last data bit (counter = WIDTH-1) without PARITY_EN: tx_done = 1. If a transfer occurs in the same cycle, reload and stay in SHIFT; otherwise go to IDLE.
  - PARITY (only with PARITY_EN): one cycle, ser_valid = 1, tx_done = 1, load_ready = 1. On transfer go to SHIFT, else go to IDLE.
- Latency: word accepted at edge N, then first bit on ser_out/ser_valid in cycle N+1, last data bit in cycle N+WIDTH. Outputs are registered.
- Throughput: one word per WIDTH cycles (WIDTH+1 with PARITY_EN) when load_valid is held high continuously.
- Counter width is $clog2(WIDTH). It wraps to 0 on reload and never counts past WIDTH-1.
- Reset mid-word: the word is abandoned with no partial completion. ser_valid = 0 and tx_done = 0 in the cycle after the reset edge, and load_ready = 1 in the first cycle after rst falls.
- Transfer and rst asserted in the same cycle: reset wins and the word is not loaded. This cannot occur legally because load_ready = 0 during rst.

Optional Feature:
Macro PARITY_EN.
- Defined: after the last data bit, one extra serial bit carries even parity, the XOR of all WIDTH data bits, latched at load. ser_valid = 1 and tx_done = 1 move to the parity cycle, and load_ready is asserted in the parity cycle rather than the last data cycle. Frame length is WIDTH+1.
- Undefined: no PARITY state, no parity logic, frame length is WIDTH.

Test Plan:
1. Reset: hold rst = 1 for 3 cycles with load_valid = 1 -> load_ready = 0, ser_valid = 0, ser_out = 0, busy = 0, tx_done = 0 throughout; load_ready = 1 in the first cycle after rst falls.
2. Single word, WIDTH = 4, MSB_FIRST = 0: load 4'b1011 at edge N -> ser_out = 1, 1, 0, 1 in cycles N+1..N+4, ser_valid = 1 and busy = 1 in exactly those cycles, tx_done = 1 only in N+4, IDLE at N+5.
3. Back-to-back: load_valid held with 4'hA, then 4'h5 accepted in the last-bit cycle -> 8 contiguous valid bits 0, 1, 0, 1, 1, 0, 1, 0; tx_done in cycles N+4 and N+8; no gap.
4. Backpressure: assert load_valid with 4'h3 at N+2 while busy -> no transfer until the last-bit cycle N+4; 4'h3 bits start at N+5, and the in-flight word is uncorrupted.
5. Reset mid-word: load 4'hF, assert rst in cycle N+2 -> ser_valid = 0 from N+3, tx_done never pulses, next word 4'h1 after reset transmits 1, 0, 0, 0 correctly.
6. PARITY_EN defined, MSB_FIRST = 1: load 4'b0111 -> ser_out = 0, 1, 1, 1 then parity 1 in cycle N+5, tx_done only in N+5, load_ready = 1 in N+5 and not in N+4.
